// File: rtl/kuznechik_pkg.sv
// kuznechik_pkg: shared definitions for the Kuznechik (GOST R 34.12-2015)
// cipher and decipher blocks.
//   block_t / byte_t    : 128-bit block and byte types
//   PI / PI_INV         : forward and inverse byte substitution tables
//   L_COEFF             : coefficients of the linear function l(), indexed by byte position
//   ROUND_KEYS_DEFAULT  : expanded round keys K1..K10 for the reference key
//   gf_mul              : multiply in GF(2^8) modulo x^8+x^7+x^6+x+1
//   ST_*                : FSM state encodings
package kuznechik_pkg;

    typedef logic [127:0]          block_t;
    typedef logic [7:0]            byte_t;
    typedef logic [0:255][7:0]     sbox_t;
    typedef logic [1:10][127:0]    round_keys_t;
    typedef logic [2:0]            fsm_state_t;

    localparam fsm_state_t ST_IDLE = 3'd0;
    localparam fsm_state_t ST_KEY  = 3'd1;
    localparam fsm_state_t ST_LINV = 3'd2;
    localparam fsm_state_t ST_SINV = 3'd3;
    localparam fsm_state_t ST_DONE = 3'd4;

    localparam sbox_t PI = '{
        252, 238, 221,  17, 207, 110,  49,  22, 251, 196, 250, 218,  35, 197,   4,  77,
        233, 119, 240, 219, 147,  46, 153, 186,  23,  54, 241, 187,  20, 205,  95, 193,
        249,  24, 101,  90, 226,  92, 239,  33, 129,  28,  60,  66, 139,   1, 142,  79,
          5, 132,   2, 174, 227, 106, 143, 160,   6,  11, 237, 152, 127, 212, 211,  31,
        235,  52,  44,  81, 234, 200,  72, 171, 242,  42, 104, 162, 253,  58, 206, 204,
        181, 112,  14,  86,   8,  12, 118,  18, 191, 114,  19,  71, 156, 183,  93, 135,
         21, 161, 150,  41,  16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
         50, 117,  25,  61, 255,  53, 138, 126, 109,  84, 198, 128, 195, 189,  13,  87,
        223, 245,  36, 169,  62, 168,  67, 201, 215, 121, 214, 246, 124,  34, 185,   3,
        224,  15, 236, 222, 122, 148, 176, 188, 220, 232,  40,  80,  78,  51,  10,  74,
        167, 151,  96, 115,  30,   0,  98,  68,  26, 184,  56, 130, 100, 159,  38,  65,
        173,  69,  70, 146,  39,  94,  85,  47, 140, 163, 165, 125, 105, 213, 149,  59,
          7,  88, 179,  64, 134, 172,  29, 247,  48,  55, 107, 228, 136, 217, 231, 137,
        225,  27, 131,  73,  76,  63, 248, 254, 141,  83, 170, 144, 202, 216, 133,  97,
         32, 113, 103, 164,  45,  43,   9,  91, 203, 155,  37, 208, 190, 229, 108,  82,
         89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194,  57,  75,  99, 182
    };

    // The inverse table is derived from PI at elaboration so the two can never
    // disagree.
    function automatic sbox_t invert_sbox(input sbox_t s);
        sbox_t r;
        r = '0;
        for (int i = 0; i < 256; i++) r[s[i]] = byte_t'(i);
        return r;
    endfunction

    localparam sbox_t PI_INV = invert_sbox(PI);

    // L_COEFF[i] multiplies byte a_i (bits [8i+7:8i]); a15 -> 148 ... a0 -> 1.
    localparam logic [15:0][7:0] L_COEFF = {
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    localparam round_keys_t ROUND_KEYS_DEFAULT = '{
        128'h8899aabbccddeeff0011223344556677,
        128'hfedcba98765432100123456789abcdef,
        128'hdb31485315694343228d6aef8cc78c44,
        128'h3d4553d8e9cfec6815ebadc40a9ffd04,
        128'h57646468c44a5e28d3e59246f429f1ac,
        128'hbd079435165c6432b532e82834da581b,
        128'h51e640757e8745de705727265a0098b1,
        128'h5a7925017b9fdd3ed72a91a22286f984,
        128'hbb44e25378c73123a5f32f73cdb6e517,
        128'h72e9dd7416bcf45b755dbaa88e4a4043
    };

    // Shift-and-add multiply; the carry out of bit 7 folds back as 0xC3.
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/kuznechik_l_func.sv
// kuznechik_l_func: combinational linear function l() of the Kuznechik
// linear layer.
//   blk   in  128  bytes a15 (bits 127:120) .. a0 (bits 7:0)
//   l_out out 8    sum over i of L_COEFF[i] * a_i in GF(2^8)
module kuznechik_l_func
    import kuznechik_pkg::*;
(
    input  block_t blk,
    output byte_t  l_out
);

    always_comb begin
        l_out = '0;
        for (int i = 0; i < 16; i++) begin
            l_out = l_out ^ gf_mul(L_COEFF[i], blk[i*8 +: 8]);
        end
    end

endmodule

// File: rtl/kuznechik_decipher.sv
// kuznechik_decipher: iterative Kuznechik block decryption, one 128-bit
// block per request. Inverse linear layer is byte-serial (16 cycles/round).
//   clk_i      in  1    clock, rising edge
//   rst_i      in  1    asynchronous active-high reset
//   data_i     in  128  ciphertext, sampled when a request is accepted in IDLE
//   request_i  in  1    start request, honoured only in IDLE
//   ack_i      in  1    result consumed, honoured only in DONE
//   data_o     out 128  plaintext, meaningful while valid_o=1
//   valid_o    out 1    result available
//   busy_o     out 1    computing or holding an unacknowledged result
module kuznechik_decipher
    import kuznechik_pkg::*;
#(
    parameter round_keys_t ROUND_KEYS = ROUND_KEYS_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [127:0] data_i,
    input  logic         request_i,
    input  logic         ack_i,
    output logic [127:0] data_o,
    output logic         valid_o,
    output logic         busy_o
);

    fsm_state_t fsm_q;
    block_t     state_q;
    logic [3:0] round_q;
    logic [3:0] step_q;
    byte_t      l_val;
    block_t     sinv_state;

    // R^-1 feeds l() with the block rotated left by one byte (a14..a0, a15).
    kuznechik_l_func u_l_func (
        .blk   ({state_q[119:0], state_q[127:120]}),
        .l_out (l_val)
    );

    for (genvar i = 0; i < 16; i++) begin : g_sinv
        assign sinv_state[i*8 +: 8] = PI_INV[state_q[i*8 +: 8]];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            round_q <= '0;
            step_q  <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (request_i) begin
                        state_q <= data_i;
                        round_q <= 4'd10;
                        fsm_q   <= ST_KEY;
                    end
                end
                ST_KEY: begin
                    state_q <= state_q ^ ROUND_KEYS[round_q];
                    if (round_q == 4'd1) begin
                        fsm_q <= ST_DONE;
                    end else begin
                        round_q <= round_q - 4'd1;
                        step_q  <= '0;
                        fsm_q   <= ST_LINV;
                    end
                end
                ST_LINV: begin
                    state_q <= {state_q[119:0], l_val};
                    step_q  <= step_q + 4'd1;
                    if (step_q == 4'd15) fsm_q <= ST_SINV;
                end
                ST_SINV: begin
                    state_q <= sinv_state;
                    fsm_q   <= ST_KEY;
                end
                ST_DONE: begin
                    // A simultaneous request is deliberately dropped here.
                    if (ack_i) fsm_q <= ST_IDLE;
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from registers so reset clears them at once.
    assign data_o  = state_q;
    assign valid_o = (fsm_q == ST_DONE);
    assign busy_o  = (fsm_q != ST_IDLE);

endmodule

// File: tb/tb_kuznechik_decipher.sv
module tb_kuznechik_decipher;
    import kuznechik_pkg::*;

    localparam round_keys_t TB_KEYS = '{
        128'h8899aabbccddeeff0011223344556677,
        128'hfedcba98765432100123456789abcdef,
        128'hdb31485315694343228d6aef8cc78c44,
        128'h3d4553d8e9cfec6815ebadc40a9ffd04,
        128'h57646468c44a5e28d3e59246f429f1ac,
        128'hbd079435165c6432b532e82834da581b,
        128'h51e640757e8745de705727265a0098b1,
        128'h5a7925017b9fdd3ed72a91a22286f984,
        128'hbb44e25378c73123a5f32f73cdb6e517,
        128'h72e9dd7416bcf45b755dbaa88e4a4043
    };

    // Reference ECB pairs for the standard key.
    localparam logic [127:0] P0 = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] C0 = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbcceeff0a;
    localparam logic [127:0] C1 = 128'hb429912c6e0032f9285452d76718d08b;
    localparam logic [127:0] P2 = 128'h112233445566778899aabbcceeff0a00;
    localparam logic [127:0] C2 = 128'hf0ca33549d247ceef3f5a5313bd4b157;
    localparam logic [127:0] P3 = 128'h2233445566778899aabbcceeff0a0011;
    localparam logic [127:0] C3 = 128'hd0b09ccde830b9eb3a02c4c5aa8ada98;
    localparam int LATENCY = 163;

    logic         clk;
    logic         rst;
    logic [127:0] data_i;
    logic         request_i;
    logic         ack_i;
    logic [127:0] data_o;
    logic         valid_o;
    logic         busy_o;

    int checks;
    int errors;

    kuznechik_decipher #(.ROUND_KEYS(TB_KEYS)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .data_i    (data_i),
        .request_i (request_i),
        .ack_i     (ack_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns with request_i dropped.
    task automatic start_op(input logic [127:0] ct);
        data_i    = ct;
        request_i = 1'b1;
        tick();
        request_i = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!valid_o && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++;
        if (data_o !== 128'h0) begin errors++; $display("FAIL reset_data got %h want 0", data_o); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_gost_vector();
        int cyc;
        data_i    = C0;
        request_i = 1'b1;
        tick();                       // accepting edge
        // Request held high after acceptance must not restart anything.
        cyc = 0;
        for (int i = 0; i < 3; i++) begin tick(); cyc++; end
        request_i = 1'b0;
        data_i    = '1;
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL gost_busy got %b want 1", busy_o); end
        while (!valid_o && cyc < 400) begin tick(); cyc++; end
        checks++;
        if (cyc != LATENCY) begin errors++; $display("FAIL gost_latency got %0d want %0d", cyc, LATENCY); end
        checks++;
        if (data_o !== P0) begin errors++; $display("FAIL gost_data got %h want %h", data_o, P0); end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] ct [4];
        logic [127:0] pt [4];
        int cyc;
        ct = '{C0, C1, C2, C3};
        pt = '{P0, P1, P2, P3};
        for (int v = 0; v < 4; v++) begin
            cyc = 0;
            while (busy_o && cyc < 400) begin tick(); cyc++; end
            start_op(ct[v]);
            wait_valid(cyc);
            checks++;
            if (valid_o !== 1'b1 || data_o !== pt[v]) begin
                errors++;
                $display("FAIL b2b_%0d got %h valid %b want %h", v, data_o, valid_o, pt[v]);
            end
            ack_i = 1'b1;
            tick();
            ack_i = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        start_op(C1);
        wait_valid(cyc);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            data_i    = {$urandom, $urandom, $urandom, $urandom};
            request_i = i[0];
            tick();
            checks++;
            if (valid_o !== 1'b1 || busy_o !== 1'b1 || data_o !== P1) begin
                errors++;
                $display("FAIL hold_%0d got %h v%b b%b want %h", i, data_o, valid_o, busy_o, P1);
            end
        end
        request_i = 1'b0;
        ack_i     = 1'b1;
        tick();
        ack_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL hold_release got v%b b%b want v0 b0", valid_o, busy_o);
        end
        checks++;
        if (data_o !== P1) begin errors++; $display("FAIL hold_keep got %h want %h", data_o, P1); end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL hold_noqueue got busy %b want 0", busy_o); end
    endtask

    task automatic test_misuse();
        int cyc;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || data_o !== P1) begin
            errors++; $display("FAIL idle_ack got %h v%b b%b want %h v0 b0", data_o, valid_o, busy_o, P1);
        end
        start_op(C2);
        wait_valid(cyc);
        checks++;
        if (data_o !== P2) begin errors++; $display("FAIL misuse_data got %h want %h", data_o, P2); end
        data_i    = C0;
        request_i = 1'b1;
        ack_i     = 1'b1;
        tick();
        request_i = 1'b0;
        ack_i     = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL req_ack got v%b b%b want v0 b0", valid_o, busy_o);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (busy_o !== 1'b0 || data_o !== P2) begin
            errors++; $display("FAIL req_ack_drop got %h b%b want %h b0", data_o, busy_o, P2);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_op(C3);
        for (int i = 0; i < 49; i++) tick();
        #3 rst = 1'b1;                // between edges
        #1;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || data_o !== 128'h0) begin
            errors++; $display("FAIL mid_reset got %h v%b b%b want 0 v0 b0", data_o, valid_o, busy_o);
        end
        tick();
        rst = 1'b0;
        tick();
        start_op(C3);
        wait_valid(cyc);
        checks++;
        if (cyc != LATENCY) begin errors++; $display("FAIL post_reset_latency got %0d want %0d", cyc, LATENCY); end
        checks++;
        if (data_o !== P3) begin errors++; $display("FAIL post_reset_data got %h want %h", data_o, P3); end
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        data_i    = '0;
        request_i = 1'b0;
        ack_i     = 1'b0;
        test_reset();
        test_gost_vector();
        test_back_to_back();
        test_backpressure();
        test_misuse();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kuznechik_decipher.md
Name: kuznechik_decipher

Overview:
- Inverse of kuznechik_cipher: decrypts one 128-bit GOST R 34.12-2015 (Kuznechik) block per request.
- Uses the same request/ack/valid/busy handshake as the cipher, so the two are interchangeable behind one host and can be chained for round-trip checks.
- Iterative datapath with byte-serial inverse linear transform; round keys are precomputed constants.

Parameters:
- ROUND_KEYS, default kuznechik_pkg::ROUND_KEYS_DEFAULT, array of 10 x 128-bit round keys K1..K10 (same key set as the cipher).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- data_i  in  128  ciphertext; sampled on the accepted request.
- request_i  in  1  start request; honoured only in IDLE.
- ack_i  in  1  host has consumed data_o; honoured only in DONE.
- data_o  out  128  plaintext; valid while valid_o=1.
- valid_o  out  1  result available.
- busy_o  out  1  block occupied (computing or holding an unacked result).

Behaviour:
- Reset: asynchronous, active-high, effective at any time including mid-operation.
  - State returns to IDLE.
  - data_o=0, valid_o=0, busy_o=0; internal state register and round counter cleared.
- Byte order: a15 = bits[127:120] ... a0 = bits[7:0].
- Datapath primitives:
  - X[K]: state ^ K.
  - S^-1: per-byte inverse pi table.
  - l(a15..a0) = 148a15+32a14+133a13+16a12+194a11+192a10+1a9+251a8+1a7+192a6+194a5+16a4+133a3+32a2+148a1+1a0, computed in GF(2^8) mod x^8+x^7+x^6+x+1.
  - R^-1(a) = a14..a0 || l(a14,...,a0,a15).
  - L^-1 = 16 applications of R^-1, one per cycle.
- FSM states: IDLE, KEY, LINV, SINV, DONE.
  - IDLE: busy_o=0. On request_i=1, latch data_i into state, set busy_o=1, set round r=10, go to KEY.
  - KEY: state ^= ROUND_KEYS[r]. If r=1, go to DONE. Otherwise r--, clear step counter, go to LINV.
  - LINV: one R^-1 per cycle. After the 16th step, go to SINV.
  - SINV: apply S^-1 to all bytes, go to KEY.
- Operation sequence: X[K10], then for r=9..1: L^-1, S^-1, X[Kr].
- Latency: valid_o rises exactly 163 cycles after the accepting clock edge (1 + 9 x 18). The count is fixed and does not depend on the data.
- DONE:
  - valid_o=1, busy_o=1, data_o = state, held stable indefinitely until ack_i=1.
  - On ack_i, the next cycle has valid_o=0, busy_o=0, state IDLE.
  - data_o keeps its last value after ack; it has no meaning while valid_o=0.
- Boundary cases:
  - request_i outside IDLE: ignored; it does not queue.
  - ack_i outside DONE: ignored.
  - request_i and ack_i together in DONE: ack is processed, request is dropped. The host must re-request after busy_o falls.
  - request_i held high in IDLE: accepted once.
  - data_i changes after acceptance: no effect on the block in flight.
- No X propagation from unused data_i while in IDLE.

Decomposition:
- kuznechik_pkg (shared with kuznechik_cipher) contains:
  - block_t (logic [127:0]), byte_t.
  - PI and PI_INV tables as constant arrays of 256 bytes.
  - L_COEFF[16].
  - ROUND_KEYS_DEFAULT.
  - gf_mul function (mod 0x1C3).
  - FSM state enum.
- Sub-module kuznechik_l_func: combinational l() over 16 bytes. Reused by the cipher's R step.

Test Plan:
- Standard GOST vector:
  - Stimulus: ROUND_KEYS overridden to the standard keys (K1=8899aabbccddeeff0011223344556677 ... K10=72e9dd7416bcf45b755dbaa88e4a4043); request with data_i=7f679d90bebc24305a468d42b9d4edcd.
  - Response: data_o=1122334455667700ffeeddccbbaa9988, valid_o asserted exactly 163 cycles after acceptance.
- Round trip:
  - Stimulus: feed the 11 cipher output blocks (cipher inputs a5ff3b17aa3368ffeda5d628bc671622 ... ea89bd191958c6bf0d2890ded315cd5d, default keys) back-to-back through the decipher, using the busy/request/valid/ack loop.
  - Response: every output equals the original plaintext block; the concatenated ASCII prints the original message.
- Back-pressure:
  - Stimulus: hold ack_i=0 for 40 cycles after valid_o rises; toggle data_i and request_i during that time.
  - Response: valid_o=1, busy_o=1 and data_o unchanged throughout; no second operation starts.
- Reset mid-operation:
  - Stimulus: assert rst_i asynchronously 50 cycles into a decryption, between clock edges.
  - Response: valid_o, busy_o and data_o go to 0 immediately; a following request decrypts correctly in 163 cycles.
- Protocol misuse:
  - Stimulus: ack_i pulse in IDLE, then request_i+ack_i together in DONE.
  - Response: no state change in IDLE; in DONE the result is released, state is IDLE with busy_o=0, and no new operation starts.
